instr_feeder: RTL and testbench

- Upstream stage of the core instruction port.
- Accepts a byte-wide instruction stream from a host or loader.
- Assembles each group of 4 bytes, little-endian, into a 32-bit instruction word.
- Buffers assembled words in a DEPTH-entry FIFO and presents them to the core over a valid/ready handshake (o_instr/o_valid/i_ready drive the core's i_instr/i_valid/o_ready).

---
 rtl/instr_feeder.sv | 99 +++++++++
 tb/tb_instr_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Byte-to-word instruction feeder: packs little-endian byte groups into 32-bit
// words and queues them in a small FIFO for the core's valid/ready port.
module instr_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic              i_flush,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [31:0]       o_instr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [23:0]       lanes_q, lanes_d;
  logic              byteAcc, push, pop;

  assign o_count      = count_q;
  assign o_full       = (count_q == FullCount);
  assign o_empty      = (count_q == '0);
  assign o_valid      = !o_empty;
  assign o_instr      = mem_q[rdPtr_q];
  // Stall only the word-completing byte when full; a same-cycle pop never opens the slot early.
  assign o_byte_ready = !((byteCnt_q == 2'd3) && o_full);

  assign byteAcc = i_byte_valid && o_byte_ready;
  assign push    = byteAcc && (byteCnt_q == 2'd3);
  assign pop     = o_valid && i_ready;

  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    byteCnt_d = byteCnt_q;
    lanes_d   = lanes_q;
    if (i_flush) begin
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      byteCnt_d = '0;
      lanes_d   = '0;
    end else begin
      if (byteAcc) begin
        if (byteCnt_q == 2'd3) begin
          wrPtr_d   = wrPtr_q + ADDR_W'(1);
          byteCnt_d = 2'd0;
        end else begin
          lanes_d[byteCnt_q*8 +: 8] = i_byte;
          byteCnt_d = byteCnt_q + 2'd1;
        end
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      byteCnt_q <= '0;
      lanes_q   <= '0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      byteCnt_q <= byteCnt_d;
      lanes_q   <= lanes_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge i_CLK) begin
    if (push && !i_flush) begin
      mem_q[wrPtr_q] <= {i_byte, lanes_q};
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: a byte-level model predicts every word,
// the FIFO occupancy flags and the byte-ready stall.
module tb_instr_feeder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              i_CLK = 1'b0;
  logic              i_RSTn;
  logic              i_flush;
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [31:0]       o_instr;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_empty;

  int                errCount   = 0;
  int                checkCount = 0;
  int                popCount   = 0;
  int                maxCnt     = 0;
  logic [31:0]       expQ[$];
  int                partCnt    = 0;
  logic [23:0]       partLanes  = '0;

  instr_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_flush(i_flush),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_instr(o_instr), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: on each falling edge compare occupancy against the queue, then
  // apply what the next rising edge will do (flush, pop, byte accept).
  always @(negedge i_CLK) begin
    logic expFull, expReady;
    logic [31:0] expWord;
    if (!i_RSTn) begin
      expQ.delete();
      partCnt   = 0;
      partLanes = '0;
    end else begin
      expFull  = (expQ.size() == DEPTH);
      expReady = !(partCnt == 3 && expFull);
      checkOutput("count", 32'(o_count), 32'(expQ.size()));
      checkOutput("valid", 32'(o_valid), 32'(expQ.size() != 0));
      checkOutput("empty", 32'(o_empty), 32'(expQ.size() == 0));
      checkOutput("full", 32'(o_full), 32'(expFull));
      checkOutput("byteReady", 32'(o_byte_ready), 32'(expReady));
      if (int'(o_count) > maxCnt) maxCnt = int'(o_count);
      if (i_flush) begin
        expQ.delete();
        partCnt   = 0;
        partLanes = '0;
      end else begin
        if (expQ.size() != 0 && i_ready) begin
          expWord = expQ.pop_front();
          checkOutput("instr", o_instr, expWord);
          popCount++;
        end
        if (i_byte_valid && expReady) begin
          if (partCnt == 3) begin
            expQ.push_back({i_byte, partLanes});
            partCnt = 0;
          end else begin
            partLanes[partCnt*8 +: 8] = i_byte;
            partCnt++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge i_CLK);
      acc = o_byte_ready;
      @(posedge i_CLK);
      #1;
      n++;
    end
    if (!acc) checkOutput("byteAcceptTimeout", 32'(acc), 32'd1);
    i_byte_valid = 1'b0;
  endtask

  task automatic drainFifo();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (n < 200) begin
      @(negedge i_CLK);
      if (o_empty) break;
      n++;
    end
    checkOutput("drainDone", 32'(o_empty), 32'd1);
    @(posedge i_CLK);
    #1;
    i_ready = 1'b0;
  endtask

  initial begin
    int pops0;
    i_RSTn = 1'b0; i_flush = 1'b0; i_byte = '0; i_byte_valid = 1'b0; i_ready = 1'b0;
    #12;
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstEmpty", 32'(o_empty), 32'd1);
    checkOutput("rstFull", 32'(o_full), 32'd0);
    checkOutput("rstCount", 32'(o_count), 32'd0);
    checkOutput("rstByteReady", 32'(o_byte_ready), 32'd1);
    #10;
    i_RSTn = 1'b1;
    @(posedge i_CLK); #1;

    // First word becomes visible the cycle after its fourth byte.
    applyStimulus(8'h13); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h02);
    checkOutput("t1Valid", 32'(o_valid), 32'd1);
    checkOutput("t1Instr", o_instr, 32'h02010013);
    checkOutput("t1Count", 32'(o_count), 32'd1);
    drainFifo();

    // Fill to full, then stall the word-completing byte until a pop frees a slot.
    for (int i = 0; i < 32; i++) applyStimulus(8'(i));
    checkOutput("t2Full", 32'(o_full), 32'd1);
    checkOutput("t2Count", 32'(o_count), 32'd8);
    applyStimulus(8'h20); applyStimulus(8'h21); applyStimulus(8'h22);
    i_byte = 8'h23; i_byte_valid = 1'b1;
    @(negedge i_CLK);
    checkOutput("t2Stall", 32'(o_byte_ready), 32'd0);
    checkOutput("t2Head0", o_instr, 32'h03020100);
    @(posedge i_CLK); #1;
    i_ready = 1'b1;
    @(posedge i_CLK); #1;
    i_ready = 1'b0;
    checkOutput("t2Head1", o_instr, 32'h07060504);
    checkOutput("t2Count7", 32'(o_count), 32'd7);
    @(posedge i_CLK); #1;
    i_byte_valid = 1'b0;
    checkOutput("t2Count8", 32'(o_count), 32'd8);
    drainFifo();

    // Streaming with the core always ready; pointers wrap past DEPTH.
    pops0 = popCount;
    maxCnt = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(8'(8'h40 + i));
    drainFifo();
    checkOutput("t3Pops", 32'(popCount - pops0), 32'd10);
    checkOutput("t3MaxCount", 32'(maxCnt), 32'd1);

    // Push and pop in one cycle at count 3.
    for (int i = 0; i < 12; i++) applyStimulus(8'(8'hA0 + i));
    applyStimulus(8'hB0); applyStimulus(8'hB1); applyStimulus(8'hB2);
    i_byte = 8'hB3; i_byte_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_CLK); #1;
    i_byte_valid = 1'b0; i_ready = 1'b0;
    checkOutput("t4Count", 32'(o_count), 32'd3);
    checkOutput("t4Head", o_instr, 32'hA7A6A5A4);
    drainFifo();

    // Flush discards stored words and the partial word.
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    applyStimulus(8'hAA); applyStimulus(8'hBB);
    i_flush = 1'b1;
    @(posedge i_CLK); #1;
    i_flush = 1'b0;
    checkOutput("t5Count", 32'(o_count), 32'd0);
    checkOutput("t5Valid", 32'(o_valid), 32'd0);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    checkOutput("t5Instr", o_instr, 32'h44332211);
    drainFifo();

    // Asynchronous reset mid-stream with 5 words and 2 partial bytes held.
    for (int i = 0; i < 22; i++) applyStimulus(8'(8'h60 + i));
    checkOutput("t6PreCount", 32'(o_count), 32'd5);
    #2;
    i_RSTn = 1'b0;
    #1;
    checkOutput("t6Valid", 32'(o_valid), 32'd0);
    checkOutput("t6Count", 32'(o_count), 32'd0);
    checkOutput("t6ByteReady", 32'(o_byte_ready), 32'd1);
    @(negedge i_CLK);
    #2;
    i_RSTn = 1'b1;
    @(posedge i_CLK); #1;
    applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
    checkOutput("t6Instr", o_instr, 32'hEFBEADDE);
    checkOutput("t6CountAfter", 32'(o_count), 32'd1);
    drainFifo();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
